// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared encodings for the bit-serial add/sub controller
//
// Purpose: state and operation encodings shared by the controller and its bench.
// Ports:   none (package).
package serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/serial_addsub_ctrl_addsub_cell.sv
// rtl/serial_addsub_ctrl_addsub_cell.sv - combinational 1-bit add/subtract cell
//
// Purpose: one full-adder bit whose B input is conditionally inverted, so a
//          carry-in of 1 together with sel=1 yields A + ~B + 1 = A - B.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   sel   in   0 = add, 1 = subtract (inverts b)
//   s     out  sum bit
//   cout  out  carry out
module addsub_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic s,
  output logic cout
);

  logic bx;

  assign bx   = b ^ sel;
  assign s    = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial adder/subtractor controller
//
// Purpose: sequences a single addsub_cell over a WIDTH-bit operand pair, LSB
//          first, one bit per clock, keeping the inter-bit carry in a flop.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   request, sampled only while idle
//   a, b    in   WIDTH-bit operands, sampled with start
//   sub     in   0 = A+B, 1 = A-B, sampled with start
//   busy    out  high from the accepting edge until back in IDLE
//   done    out  one-cycle pulse; result/cout/ovf are new in that cycle
//   result  out  WIDTH-bit sum/difference, modulo 2^WIDTH
//   cout    out  carry out of the MSB (for sub: 1 = no borrow)
//   ovf     out  signed overflow
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic             busy_nx;
  logic             done_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  op_t              op;
  logic [CW-1:0]    cnt;

  logic             last_bit;
  logic             cell_s;
  logic             cell_c;
  logic             c_msb_in;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // On the last bit the carry flop holds the carry into the MSB; overflow is
  // the disagreement between carry into and carry out of the MSB.
  assign c_msb_in = carry;

  addsub_cell u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sel  (op == OP_SUB),
    .s    (cell_s),
    .cout (cell_c)
  );

  // State register; busy/done are registered copies of the next-state decode
  // so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)    state_nx = ST_RUN;
      ST_RUN:  if (last_bit) state_nx = ST_DONE;
      ST_DONE:               state_nx = ST_IDLE;
      default:               state_nx = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state_nx == ST_DONE);
  end

  // Datapath: operand shifters, carry, counter, result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      carry  <= 1'b0;
      op     <= OP_ADD;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            op    <= sub ? OP_SUB : OP_ADD;
            // Carry-in of 1 supplies the +1 of the two's-complement negate.
            carry <= sub;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          sr    <= {cell_s, sr[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= cell_c;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            // The final sum bit is folded in here so result is complete on
            // the same edge that enters DONE.
            result <= {cell_s, sr[WIDTH-1:1]};
            cout   <= cell_c;
            ovf    <= cell_c ^ c_msb_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
